// File: rtl/lsu_pkg.sv
// Shared encodings and address-map constants for the load/store MMIO unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    RG_DMEM,
    RG_OUT,
    RG_IN,
    RG_UNMAP
  } region_e;

  // Region selectors: DMEM by upper-bit value, OUT/IN by base address
  localparam int unsigned DMEM_SEL = 1;
  localparam int unsigned OUT_BASE = 32'h7000;
  localparam int unsigned IN_BASE  = 32'h7800;

  localparam logic [5:0] OUT_LEDR_OFF = 6'h00;
  localparam logic [5:0] OUT_LEDG_OFF = 6'h10;
  localparam logic [5:0] OUT_HEX_OFF  = 6'h20;
  localparam logic [5:0] OUT_LCD_OFF  = 6'h30;
  localparam logic [4:0] IN_SW_OFF    = 5'h00;
  localparam logic [4:0] IN_BTN_OFF   = 5'h10;

  // Byte-lane enables for an access of the given size at lane 0
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_mask = 4'b0001;
      SZ_HALF: size_mask = 4'b0011;
      SZ_WORD: size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_sync2.sv
// Two-flop synchroniser for asynchronous inputs, parametrised width.
module lsu_sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] meta_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= '0;
      o_q    <= '0;
    end else begin
      meta_q <= i_d;
      o_q    <= meta_q;
    end
  end

endmodule

// File: rtl/lsu_mmio.sv
// Load/store unit with data memory and memory-mapped LED/HEX/LCD/switch I/O.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being forced aligned.
module lsu_mmio
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DMEM_AW = 13,
  parameter int unsigned HEX_CNT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req,
  input  logic                 i_wren,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  input  logic [31:0]          i_st_data,
  input  logic [31:0]          i_io_sw,
  input  logic [3:0]           i_io_btn,
  output logic                 o_ready,
  output logic                 o_rvalid,
  output logic [31:0]          o_ld_data,
  output logic                 o_fault,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [31:0]          o_io_lcd,
  output logic [7*HEX_CNT-1:0] o_io_hex
);

  localparam int unsigned WIDX_W     = DMEM_AW - 2;
  localparam int unsigned DMEM_WORDS = 2 ** WIDX_W;

  typedef enum logic {S_IDLE, S_RESP} state_e;

  state_e       state_q, state_d;
  logic [31:0]  dmem [DMEM_WORDS];
  logic [31:0]  ledr_q, ledg_q, lcd_q;
  logic [7:0]   hex_q [HEX_CNT];
  logic [31:0]  sw_s;
  logic [3:0]   btn_s;

  logic [ADDR_W-1:0] ea_c;
  logic [1:0]   lane_c;
  region_e      region_c;
  logic         misalign_c, fault_c, accept_c, do_st_c;
  logic [3:0]   be_c;
  logic [31:0]  wdata_c, rword_c, rsh_c, ext_c, ld_c;

  lsu_sync2 #(.W(32)) u_sync_sw  (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_io_sw),  .o_q(sw_s));
  lsu_sync2 #(.W(4))  u_sync_btn (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_io_btn), .o_q(btn_s));

  // Effective address and alignment handling
  always_comb begin
    ea_c       = i_addr;
    misalign_c = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_c = ((i_size == SZ_HALF) && i_addr[0]) || ((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00));
`else
    if (i_size == SZ_HALF) ea_c[0] = 1'b0;
    if (i_size == SZ_WORD) ea_c[1:0] = 2'b00;
`endif
  end

  always_comb begin
    region_c = RG_UNMAP;
    if (ea_c[ADDR_W-1:DMEM_AW] == (ADDR_W-DMEM_AW)'(DMEM_SEL))    region_c = RG_DMEM;
    else if (ea_c[ADDR_W-1:6] == (ADDR_W-6)'(OUT_BASE >> 6))      region_c = RG_OUT;
    else if (ea_c[ADDR_W-1:5] == (ADDR_W-5)'(IN_BASE >> 5))       region_c = RG_IN;
  end

  assign lane_c   = ea_c[1:0];
  assign fault_c  = (i_size == SZ_ILL) || (region_c == RG_UNMAP) ||
                    ((region_c == RG_IN) && i_wren) || misalign_c;
  assign accept_c = (state_q == S_IDLE) && i_req;
  assign do_st_c  = accept_c && i_wren && !fault_c;
  assign be_c     = size_mask(i_size) << lane_c;
  assign wdata_c  = i_st_data << {lane_c, 3'b000};

  // Word-granular read of the addressed region
  always_comb begin
    rword_c = '0;
    unique case (region_c)
      RG_DMEM: rword_c = dmem[ea_c[DMEM_AW-1:2]];
      RG_OUT: begin
        if (ea_c[5:2] == OUT_LEDR_OFF[5:2]) rword_c = ledr_q;
        if (ea_c[5:2] == OUT_LEDG_OFF[5:2]) rword_c = ledg_q;
        if (ea_c[5:2] == OUT_LCD_OFF[5:2])  rword_c = lcd_q;
        for (int k = 0; k < HEX_CNT; k++)
          if (ea_c[5:2] == 4'((32'(OUT_HEX_OFF) + 32'(k)) >> 2))
            rword_c[8*(k%4) +: 8] = hex_q[k];
      end
      RG_IN: begin
        if (ea_c[4:2] == IN_SW_OFF[4:2])  rword_c = sw_s;
        if (ea_c[4:2] == IN_BTN_OFF[4:2]) rword_c = {28'd0, btn_s};
      end
      default: rword_c = '0;
    endcase
  end

  always_comb begin
    rsh_c = rword_c >> {lane_c, 3'b000};
    ext_c = rsh_c;
    case (i_size)
      SZ_BYTE: ext_c = i_unsigned ? {24'd0, rsh_c[7:0]}  : {{24{rsh_c[7]}}, rsh_c[7:0]};
      SZ_HALF: ext_c = i_unsigned ? {16'd0, rsh_c[15:0]} : {{16{rsh_c[15]}}, rsh_c[15:0]};
      default: ext_c = rsh_c;
    endcase
    ld_c = fault_c ? 32'd0 : ext_c;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_req) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Response registers and memory-mapped output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ready   <= 1'b1;
      o_rvalid  <= 1'b0;
      o_fault   <= 1'b0;
      o_ld_data <= '0;
      ledr_q    <= '0;
      ledg_q    <= '0;
      lcd_q     <= '0;
      for (int k = 0; k < HEX_CNT; k++) hex_q[k] <= '0;
    end else begin
      o_ready  <= (state_d == S_IDLE);
      o_rvalid <= accept_c;
      if (accept_c) begin
        o_fault   <= fault_c;
        o_ld_data <= i_wren ? 32'd0 : ld_c;
      end
      if (do_st_c && (region_c == RG_OUT)) begin
        for (int j = 0; j < 4; j++) begin
          if (be_c[j]) begin
            if (ea_c[5:2] == OUT_LEDR_OFF[5:2]) ledr_q[8*j +: 8] <= wdata_c[8*j +: 8];
            if (ea_c[5:2] == OUT_LEDG_OFF[5:2]) ledg_q[8*j +: 8] <= wdata_c[8*j +: 8];
            if (ea_c[5:2] == OUT_LCD_OFF[5:2])  lcd_q[8*j +: 8]  <= wdata_c[8*j +: 8];
            for (int k = 0; k < HEX_CNT; k++)
              if ({ea_c[5:2], 2'(j)} == 6'(32'(OUT_HEX_OFF) + 32'(k)))
                hex_q[k] <= wdata_c[8*j +: 8];
          end
        end
      end
    end
  end

  // Data memory is deliberately not reset
  always_ff @(posedge i_clk) begin
    if (do_st_c && (region_c == RG_DMEM)) begin
      for (int j = 0; j < 4; j++)
        if (be_c[j]) dmem[ea_c[DMEM_AW-1:2]][8*j +: 8] <= wdata_c[8*j +: 8];
    end
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;

  for (genvar g = 0; g < HEX_CNT; g++) begin : g_hex
    assign o_io_hex[7*g +: 7] = hex_q[g][6:0];
  end

endmodule
